// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation and state codes are used by the unit and by anything that drives it.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int ITER = 32;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: add-or-pass for multiply,
// restoring trial-subtract for divide. The accumulator is {high half, low half}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff_s;

    // Multiply keeps the carry in the shifted-in bit; divide shifts the next dividend bit into the remainder.
    always_comb begin
        sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
        rem_s  = acc_i[2*WIDTH-1:WIDTH-1];
        diff_s = rem_s[WIDTH-1:0] - b_i;
        if (is_div_i) begin
            if (rem_s >= {1'b0, b_i}) begin
                acc_o = {diff_s, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign correction and commits.
module muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               is_div_q;
    logic               b_zero_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               signed_op_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [2*WIDTH-1:0] acc_neg_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Operand magnitudes and signs captured on the start edge.
    always_comb begin
        signed_op_s = (op == OP_MULT) || (op == OP_DIV);
        a_neg_s     = signed_op_s & SrcA[WIDTH-1];
        b_neg_s     = signed_op_s & SrcB[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = {WIDTH{1'b0}} - SrcA;
        end else begin
            a_mag_s = SrcA;
        end
        if (b_neg_s) begin
            b_mag_s = {WIDTH{1'b0}} - SrcB;
        end else begin
            b_mag_s = SrcB;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .b_i      (b_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step_s)
    );

    // Sign correction and divide-by-zero override for the commit edge.
    always_comb begin
        acc_neg_s = {(2*WIDTH){1'b0}} - acc_q;
        res_hi_s  = acc_q[2*WIDTH-1:WIDTH];
        res_lo_s  = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                res_lo_s = {WIDTH{1'b1}};
                res_hi_s = a_raw_q;
            end else begin
                if (qneg_q) begin
                    res_lo_s = acc_neg_s[WIDTH-1:0];
                end else begin
                    res_lo_s = acc_q[WIDTH-1:0];
                end
                if (rneg_q) begin
                    res_hi_s = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    res_hi_s = acc_q[2*WIDTH-1:WIDTH];
                end
            end
        end else begin
            if (qneg_q) begin
                res_hi_s = acc_neg_s[2*WIDTH-1:WIDTH];
                res_lo_s = acc_neg_s[WIDTH-1:0];
            end else begin
                res_hi_s = acc_q[2*WIDTH-1:WIDTH];
                res_lo_s = acc_q[WIDTH-1:0];
            end
        end
    end

    // Control FSM, iteration counter and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            b_q      <= {WIDTH{1'b0}};
            a_raw_q  <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= {CNT_W{1'b0}};
                        acc_q    <= {{WIDTH{1'b0}}, a_mag_s};
                        b_q      <= b_mag_s;
                        a_raw_q  <= SrcA;
                        is_div_q <= op[1];
                        b_zero_q <= (SrcB == {WIDTH{1'b0}});
                        qneg_q   <= a_neg_s ^ b_neg_s;
                        rneg_q   <= a_neg_s;
                    end
                end
                S_CALC: begin
                    done_q <= 1'b0;
                    acc_q  <= acc_step_s;
                    cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_CNT) state_q <= S_FIX;
                end
                S_FIX: begin
                    // Commit wins over any MTHI/MTLO at this edge.
                    hi_q    <= res_hi_s;
                    lo_q    <= res_lo_s;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit that receives the ALU operands (SrcA, SrcB) at the execute stage and runs MULT/MULTU/DIV/DIVU. Results go into the architectural HI/LO registers, which the unit owns. The unit also accepts MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO read path. It uses a start/busy/done handshake so the control unit can stall while an operation runs.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  launch operation; sampled only in IDLE.
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
SrcA  in  WIDTH  multiplicand or dividend.
SrcB  in  WIDTH  multiplier or divisor.
hi_we  in  1  MTHI write enable.
lo_we  in  1  MTLO write enable.
wdata  in  WIDTH  MTHI/MTLO data (rs value).
busy  out  1  operation in progress; control stalls the pipeline.
done  out  1  one-cycle pulse when HI/LO receive a result.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high) is dominant.
  - Any state goes to IDLE.
  - hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
  - An operation interrupted by reset is discarded and never signals done.
- States:
  - IDLE.
  - CALC: 32 iterations.
  - FIX: sign correction and commit.
- IDLE -> CALC when start = 1 at edge E0.
  - Latch op, |SrcA| and |SrcB| (magnitudes for signed ops).
  - Latch the result signs: quotient/product sign = sign(SrcA) XOR sign(SrcB); remainder sign = sign(SrcA).
- CALC: one step per clock, counter 0..31.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
  - At counter = 31, go to FIX.
- FIX -> IDLE at edge E33.
  - Negate results as required by the latched signs.
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - done = 1 for exactly one cycle. busy = 0 from the same edge.
- Timing:
  - busy is registered and equals 1 in CALC and FIX, i.e. for 33 cycles after E0.
  - Latency from the start edge to done is 33 clocks.
- start while busy is ignored; no queueing.
- hi_we/lo_we:
  - Honoured only when not busy; they write hi/lo at the next edge.
  - Ignored while busy.
  - In IDLE, simultaneous hi_we and start: the write takes effect, and the operation result later overwrites it.
  - At the FIX edge, the result commit has priority; any write enable at that edge is dropped.
- Divide by zero (DIV or DIVU, SrcB = 0): completes in the normal 33 cycles with lo = 32'hFFFFFFFF and hi = SrcA (raw dividend).
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Operand latching: SrcA/SrcB/op changes after E0 have no effect.
- hi/lo are stable outputs at all times, except at reset, MTHI/MTLO writes and the commit edge.

Decomposition:
- Shared package mips_muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encodings: S_IDLE, S_CALC, S_FIX.
  - constant ITER = 32.
- One natural sub-module, muldiv_step: the combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide). The top level keeps the FSM, counter, sign logic and HI/LO registers.

Test Plan:
- MULTU SrcA = 0xFFFFFFFF, SrcB = 2, start at E0 -> busy high 33 cycles; done at E33; hi = 0x00000001, lo = 0xFFFFFFFE.
- MULT SrcA = 0xFFFFFFFD (-3), SrcB = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1 (-15).
- DIV SrcA = 0xFFFFFFF9 (-7), SrcB = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- DIVU SrcA = 100, SrcB = 0 -> lo = 0xFFFFFFFF, hi = 0x00000064.
- DIVU 100/3, then a second start with new operands at cycle 5 and hi_we with wdata = 0x1234 at cycle 10 -> both ignored; result lo = 33, hi = 1; after done, hi_we with wdata = 0x1234 -> hi = 0x00001234.
- MULTU in progress, reset at cycle 10 -> next cycle busy = 0, hi = lo = 0; done never pulses; a new start then completes normally.
